// File: rtl/conv_encoder_if.sv
// ============================================================================
//  Module      : conv_encoder_if
//  Description : Handshake/data bundle between the bit source/frame consumer
//                and conv_encoder.
//                  en_ce                 input-bit strobe
//                  i_code_rate           rate select, sampled on a frame's bit 0
//                  i_tx_data             information bit
//                  i_frame_ack           consumer has taken the frame
//                  o_ready               encoder can accept a bit
//                  o_frame_valid         coded frame complete and stable
//                  o_encoder_data_frame  packed coded frame
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef CODE_RATE_2
`define CODE_RATE_2 1'b0
`endif
`ifndef CODE_RATE_3
`define CODE_RATE_3 1'b1
`endif

interface conv_encoder_if #(
    parameter int OUT_BITS = 384
) ();
    logic                en_ce;
    logic                i_code_rate;
    logic                i_tx_data;
    logic                i_frame_ack;
    logic                o_ready;
    logic                o_frame_valid;
    logic [OUT_BITS-1:0] o_encoder_data_frame;

    // Environment side: supplies bits and acknowledges frames
    modport master (
        output en_ce, i_code_rate, i_tx_data, i_frame_ack,
        input  o_ready, o_frame_valid, o_encoder_data_frame
    );

    // Encoder side
    modport slave (
        input  en_ce, i_code_rate, i_tx_data, i_frame_ack,
        output o_ready, o_frame_valid, o_encoder_data_frame
    );
endinterface

`default_nettype wire

// File: rtl/conv_encoder.sv
// ============================================================================
//  Module      : conv_encoder
//  Description : Serial K=3 convolutional encoder (g = 7,5 at rate 1/2;
//                7,5,3 at rate 1/3). Packs one frame of FRAME_BITS coded
//                information bits MSB-first into an OUT_BITS register and
//                holds it under a valid/ack handshake. No tail bits.
//  Ports       : clk     rising-edge clock
//                rst     asynchronous, active-low reset
//                enc_if  conv_encoder_if.slave (strobe, data, rate, ack,
//                        ready, valid, coded frame)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_encoder #(
    parameter int FRAME_BITS = 128,
    parameter int OUT_BITS   = 384
) (
    input  wire logic       clk,
    input  wire logic       rst,
    conv_encoder_if.slave   enc_if
);

    localparam int CNT_W = $clog2(FRAME_BITS);
    localparam int IDX_W = $clog2(OUT_BITS);

    // MSB position of bit 0's coded group for each rate
    localparam logic [IDX_W-1:0] C_TOP3 = IDX_W'(OUT_BITS - 1);
    localparam logic [IDX_W-1:0] C_TOP2 = IDX_W'(2 * FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(FRAME_BITS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENCODE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                rate_q,  rate_d;
    logic [1:0]          s_q,     s_d;      // {s1, s0}
    logic [CNT_W-1:0]    n_q,     n_d;
    logic [OUT_BITS-1:0] frame_q, frame_d;

    logic                w_ready;
    logic                w_accept;
    logic                w_first;
    logic                w_rate_eff;
    logic [1:0]          w_s_eff;
    logic [CNT_W-1:0]    w_n_eff;
    logic                w_u;
    logic                w_g0;
    logic                w_g1;
    logic                w_g2;
    logic [IDX_W-1:0]    w_idx;

    assign w_ready  = (state_q != DONE);
    assign w_accept = enc_if.en_ce & w_ready;
    assign w_first  = w_accept & (state_q == IDLE);
    assign w_u      = enc_if.i_tx_data;

    assign enc_if.o_ready              = w_ready;
    assign enc_if.o_frame_valid        = (state_q == DONE);
    assign enc_if.o_encoder_data_frame = frame_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            rate_q  <= `CODE_RATE_2;
            s_q     <= 2'b00;
            n_q     <= '0;
            frame_q <= '0;
        end else begin
            state_q <= state_d;
            rate_q  <= rate_d;
            s_q     <= s_d;
            n_q     <= n_d;
            frame_q <= frame_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rate_d     = rate_q;
        s_d        = s_q;
        n_d        = n_q;
        frame_d    = frame_q;
        w_rate_eff = rate_q;
        w_s_eff    = s_q;
        w_n_eff    = n_q;
        w_g0       = 1'b0;
        w_g1       = 1'b0;
        w_g2       = 1'b0;
        w_idx      = '0;

        // The first bit of a frame sees a freshly cleared context, so the
        // same-cycle write lands on a zeroed frame with rate taken live.
        if (w_first) begin
            w_rate_eff = enc_if.i_code_rate;
            w_s_eff    = 2'b00;
            w_n_eff    = '0;
            frame_d    = '0;
        end

        if (w_accept) begin
            w_g0 = w_u ^ w_s_eff[0] ^ w_s_eff[1];
            w_g1 = w_u ^ w_s_eff[1];
            w_g2 = w_s_eff[0] ^ w_s_eff[1];
            if (w_rate_eff == `CODE_RATE_3) begin
                w_idx = C_TOP3 - IDX_W'(3) * IDX_W'(w_n_eff);
                frame_d[w_idx]              = w_g0;
                frame_d[w_idx - IDX_W'(1)]  = w_g1;
                frame_d[w_idx - IDX_W'(2)]  = w_g2;
            end else begin
                w_idx = C_TOP2 - IDX_W'(2) * IDX_W'(w_n_eff);
                frame_d[w_idx]              = w_g0;
                frame_d[w_idx - IDX_W'(1)]  = w_g1;
            end
            s_d    = {w_s_eff[0], w_u};
            rate_d = w_rate_eff;
            n_d    = w_n_eff + CNT_W'(1);   // wraps to 0 on the last bit
        end

        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    state_d = ENCODE;
                end
            end
            ENCODE: begin
                if (w_accept && (w_n_eff == C_LAST)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (enc_if.i_frame_ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_conv_encoder.sv
// ============================================================================
//  Module      : tb_conv_encoder
//  Description : Self-checking bench for conv_encoder. Expected frames come
//                from a bit-level model of the code generators and fixed
//                reference patterns.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef CODE_RATE_2
`define CODE_RATE_2 1'b0
`endif
`ifndef CODE_RATE_3
`define CODE_RATE_3 1'b1
`endif

module tb_conv_encoder;

    localparam int C_FB = 128;
    localparam int C_OB = 384;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fails;

    conv_encoder_if #(.OUT_BITS(C_OB)) enc_bus ();

    conv_encoder #(
        .FRAME_BITS (C_FB),
        .OUT_BITS   (C_OB)
    ) u_dut (
        .clk    (clk),
        .rst    (rst),
        .enc_if (enc_bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_value(input string tag, input logic [C_OB-1:0] got,
                               input logic [C_OB-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Coded frame after the first 'count' bits, straight from the generator
    // polynomials: u = bits[n], s0 = bits[n-1], s1 = bits[n-2] (0 before start).
    function automatic logic [C_OB-1:0] ref_frame(input logic [C_FB-1:0] bits,
                                                  input logic rate3, input int count);
        logic [C_OB-1:0] f;
        logic u, s0, s1;
        f = '0;
        for (int n = 0; n < count; n++) begin
            u  = bits[n];
            s0 = (n >= 1) ? bits[n-1] : 1'b0;
            s1 = (n >= 2) ? bits[n-2] : 1'b0;
            if (rate3) begin
                f[383 - 3*n] = u ^ s0 ^ s1;
                f[382 - 3*n] = u ^ s1;
                f[381 - 3*n] = s0 ^ s1;
            end else begin
                f[255 - 2*n] = u ^ s0 ^ s1;
                f[254 - 2*n] = u ^ s1;
            end
        end
        return f;
    endfunction

    // Starts and ends just after a falling edge. en_ce stays high afterwards.
    task automatic do_frame(input string tag, input logic [C_FB-1:0] bits,
                            input logic rate, input bit toggle_rate);
        logic [C_OB-1:0] exp;
        logic            cur_rate;
        exp      = ref_frame(bits, rate == `CODE_RATE_3, C_FB);
        cur_rate = rate;
        check_value({tag, "_ready_at_start"}, C_OB'(enc_bus.o_ready), C_OB'(1'b1));
        for (int n = 0; n < C_FB; n++) begin
            enc_bus.en_ce       = 1'b1;
            enc_bus.i_tx_data   = bits[n];
            enc_bus.i_code_rate = cur_rate;
            @(negedge clk);
            if (toggle_rate) cur_rate = ~cur_rate;
            if (n == 0)
                check_value({tag, "_first_bit_latency"}, enc_bus.o_encoder_data_frame,
                            ref_frame(bits, rate == `CODE_RATE_3, 1));
            if (n == C_FB - 2)
                check_value({tag, "_valid_low_before_last"}, C_OB'(enc_bus.o_frame_valid),
                            C_OB'(1'b0));
        end
        check_value({tag, "_valid_rise"}, C_OB'(enc_bus.o_frame_valid), C_OB'(1'b1));
        check_value({tag, "_ready_fall"}, C_OB'(enc_bus.o_ready), C_OB'(1'b0));
        check_value({tag, "_frame"}, enc_bus.o_encoder_data_frame, exp);
    endtask

    // Ack with a bit presented in the same cycle; that bit must be dropped.
    task automatic do_ack(input string tag);
        logic [C_OB-1:0] held;
        held                = enc_bus.o_encoder_data_frame;
        enc_bus.i_frame_ack = 1'b1;
        enc_bus.en_ce       = 1'b1;
        enc_bus.i_tx_data   = 1'b1;
        @(negedge clk);
        enc_bus.i_frame_ack = 1'b0;
        enc_bus.en_ce       = 1'b0;
        check_value({tag, "_valid_after_ack"}, C_OB'(enc_bus.o_frame_valid), C_OB'(1'b0));
        check_value({tag, "_ready_after_ack"}, C_OB'(enc_bus.o_ready), C_OB'(1'b1));
        check_value({tag, "_ack_cycle_bit_ignored"}, enc_bus.o_encoder_data_frame, held);
    endtask

    logic [C_FB-1:0] bits;
    logic [C_FB-1:0] impulse;
    logic [C_OB-1:0] exp_c;
    logic [C_OB-1:0] held;
    logic            rnd_rate;

    initial begin
        n_checks            = 0;
        n_fails             = 0;
        impulse             = '0;
        impulse[0]          = 1'b1;
        enc_bus.en_ce       = 1'b0;
        enc_bus.i_tx_data   = 1'b0;
        enc_bus.i_code_rate = `CODE_RATE_2;
        enc_bus.i_frame_ack = 1'b0;
        rst                 = 1'b1;

        // Reset state
        #2 rst = 1'b0;
        #2;
        check_value("reset_ready", C_OB'(enc_bus.o_ready), C_OB'(1'b1));
        check_value("reset_valid", C_OB'(enc_bus.o_frame_valid), C_OB'(1'b0));
        check_value("reset_frame", enc_bus.o_encoder_data_frame, '0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Random rate-1/3 frame with the rate input toggling mid-frame
        bits = {$urandom, $urandom, $urandom, $urandom};
        do_frame("rate_latch", bits, `CODE_RATE_3, 1'b1);

        // Held in DONE while en_ce stays high with toggling data
        held = enc_bus.o_encoder_data_frame;
        for (int i = 0; i < 10; i++) begin
            enc_bus.en_ce     = 1'b1;
            enc_bus.i_tx_data = i[0];
            @(negedge clk);
            check_value("done_hold_frame", enc_bus.o_encoder_data_frame, held);
        end
        check_value("done_hold_ready", C_OB'(enc_bus.o_ready), C_OB'(1'b0));
        do_ack("hold");

        // All-zero frame must wipe the previous frame completely
        do_frame("zeros", '0, `CODE_RATE_2, 1'b0);
        check_value("zeros_const", enc_bus.o_encoder_data_frame, '0);
        do_ack("zeros");

        // Impulse, rate 1/2
        do_frame("imp2", impulse, `CODE_RATE_2, 1'b0);
        exp_c = '0;
        exp_c[255:248] = 8'hEC;
        check_value("imp2_const", enc_bus.o_encoder_data_frame, exp_c);
        do_ack("imp2");

        // Impulse, rate 1/3
        do_frame("imp3", impulse, `CODE_RATE_3, 1'b0);
        exp_c = '0;
        exp_c[383:376] = 8'hD7;
        exp_c[375]     = 1'b1;
        check_value("imp3_const", enc_bus.o_encoder_data_frame, exp_c);
        do_ack("imp3");

        // All ones, rate 1/2
        do_frame("ones", '1, `CODE_RATE_2, 1'b0);
        exp_c = '0;
        exp_c[255:0] = {8'hDA, {31{8'hAA}}};
        check_value("ones_const", enc_bus.o_encoder_data_frame, exp_c);
        do_ack("ones");

        // Random frames at random rates
        for (int k = 0; k < 4; k++) begin
            bits     = {$urandom, $urandom, $urandom, $urandom};
            rnd_rate = 1'($urandom_range(0, 1));
            do_frame("random", bits, rnd_rate, 1'b0);
            do_ack("random");
        end

        // Reset in the middle of a frame (during bit 60)
        bits = {$urandom, $urandom, $urandom, $urandom} | 128'h1;
        for (int n = 0; n <= 60; n++) begin
            enc_bus.en_ce       = 1'b1;
            enc_bus.i_tx_data   = bits[n];
            enc_bus.i_code_rate = `CODE_RATE_3;
            @(negedge clk);
        end
        #2 rst = 1'b0;
        #1;
        check_value("midreset_frame", enc_bus.o_encoder_data_frame, '0);
        check_value("midreset_ready", C_OB'(enc_bus.o_ready), C_OB'(1'b1));
        check_value("midreset_valid", C_OB'(enc_bus.o_frame_valid), C_OB'(1'b0));
        enc_bus.en_ce = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        do_frame("post_reset_imp2", impulse, `CODE_RATE_2, 1'b0);
        exp_c = '0;
        exp_c[255:248] = 8'hEC;
        check_value("post_reset_imp2_const", enc_bus.o_encoder_data_frame, exp_c);
        do_ack("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
